// File: rtl/led_pwm_driver_pkg.sv
// Shared encodings for the LED PWM driver: display modes and FSM states.
package led_pwm_driver_pkg;
  typedef enum logic [1:0] {
    MODE_PWM = 2'd0,
    MODE_BAR = 2'd1,
    MODE_BIN = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/led_pwm_driver_pwm_tick_gen.sv
// Prescaler plus PWM phase counter; both held at zero whenever run is low.
module pwm_tick_gen #(
  parameter int CNT_W    = 4,
  parameter int PRESCALE = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  output logic             tick,
  output logic [CNT_W-1:0] phase,
  output logic             wrap
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] prescale;

  assign tick = run && (prescale == PS_W'(PRESCALE - 1));
  assign wrap = tick && (phase == {CNT_W{1'b1}});

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prescale <= '0;
      phase    <= '0;
    end else if (!run) begin
      prescale <= '0;
      phase    <= '0;
    end else if (tick) begin
      prescale <= '0;
      phase    <= phase + CNT_W'(1);
    end else begin
      prescale <= prescale + PS_W'(1);
    end
  end
endmodule

// File: rtl/led_pwm_driver.sv
// LED driver: PWM dimming, bargraph, binary or off, with cnt/mode sampled only at period wraps.
module led_pwm_driver
  import led_pwm_driver_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int CNT_W    = 4,
  parameter int PRESCALE = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic [CNT_W-1:0]    cnt,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                period_done
);
  localparam int unsigned STEP = (1 << CNT_W) / NUM_LEDS;

  state_e              state;
  mode_e               mode_q;
  logic [CNT_W-1:0]    duty_q;
  logic [CNT_W-1:0]    phase;
  logic                tick, wrap, run, pwm_on;
  logic [NUM_LEDS-1:0] led_d;

  // Counters only advance while staying in RUN; en low clears them on the same edge.
  assign run = (state == RUN) && en;

  pwm_tick_gen #(.CNT_W(CNT_W), .PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .clr   (clr),
    .run   (run),
    .tick  (tick),
    .phase (phase),
    .wrap  (wrap)
  );

  assign pwm_on = (phase < duty_q);

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    localparam int unsigned THR = i * STEP;
    logic bar, bin;
    assign bar = (32'(duty_q) > THR);
    if (i < CNT_W) begin : g_bin
      assign bin = duty_q[i];
    end else begin : g_nobin
      assign bin = 1'b0;
    end
    assign led_d[i] = (mode_q == MODE_PWM) ? pwm_on :
                      (mode_q == MODE_BAR) ? bar    :
                      (mode_q == MODE_BIN) ? bin    : 1'b0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      duty_q      <= '0;
      mode_q      <= MODE_PWM;
      led         <= '0;
      period_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          led         <= '0;
          period_done <= 1'b0;
          if (en) begin
            state  <= RUN;
            duty_q <= cnt;
            mode_q <= mode_e'(mode);
          end
        end
        default: begin
          if (!en) begin
            state       <= IDLE;
            led         <= '0;
            period_done <= 1'b0;
          end else begin
            led         <= led_d;
            period_done <= wrap;
            if (wrap) begin
              duty_q <= cnt;
              mode_q <= mode_e'(mode);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_pwm_driver.sv
// Randomized and directed bench for led_pwm_driver against a period/step arithmetic model.
module tb_led_pwm_driver;
  localparam int NL = 4, CW = 4, PS = 2;
  localparam int STEPS = 1 << CW;
  localparam int PER = PS * STEPS;

  logic          clk = 0, clr = 0, en = 0;
  logic [CW-1:0] cnt = '0;
  logic [1:0]    mode = '0;
  logic [NL-1:0] led;
  logic          period_done;

  int errs = 0, checks = 0;
  bit chk_on = 0;

  led_pwm_driver #(.NUM_LEDS(NL), .CNT_W(CW), .PRESCALE(PS)) dut (
    .clk(clk), .clr(clr), .en(en), .cnt(cnt), .mode(mode),
    .led(led), .period_done(period_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NL-1:0] model_led(int ph, int duty, int md);
    logic [NL-1:0] r = '0;
    for (int i = 0; i < NL; i++)
      case (md)
        0: r[i] = (ph < duty);
        1: r[i] = (duty > i * (STEPS / NL));
        2: r[i] = (i < CW) ? ((duty >> i) & 1) : 0;
        default: r[i] = 0;
      endcase
    return r;
  endfunction

  // Reference: k counts RUN cycles since enable; period = k / PER, step = (k / PS) % STEPS.
  bit running = 0;
  int k = 0, m_duty = 0, m_mode = 0;
  logic [NL-1:0] exp_led = '0;
  logic exp_pd = 0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      running = 0; exp_led = '0; exp_pd = 0;
    end else if (!en) begin
      running = 0; exp_led = '0; exp_pd = 0;
    end else if (!running) begin
      running = 1; k = 0; m_duty = cnt; m_mode = mode;
      exp_led = '0; exp_pd = 0;
    end else begin
      exp_led = model_led((k / PS) % STEPS, m_duty, m_mode);
      exp_pd  = (k % PER) == PER - 1;
      if (exp_pd) begin m_duty = cnt; m_mode = mode; end
      k++;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("led", led, exp_led);
    chk("period_done", period_done, exp_pd);
  end

  // Runs n cycles from a negedge, counting all-on LED samples and period_done pulses.
  task automatic run_count(input int n, output int on, output int pds);
    on = 0; pds = 0;
    repeat (n) begin
      @(posedge clk); @(negedge clk);
      if (led == '1) on++;
      if (period_done) pds++;
    end
  endtask

  initial begin
    int on, pds;
    logic [NL-1:0] bar_exp [4] = '{4'b0000, 4'b0011, 4'b0111, 4'b1111};
    int bar_cnt [4] = '{0, 5, 9, 15};

    @(negedge clk);
    #2 clr = 1;
    #1 chk("reset_led", led, 0);
    chk("reset_pd", period_done, 0);
    @(negedge clk); clr = 0;
    repeat (3) @(negedge clk);
    chk("idle_led", led, 0);
    chk_on = 1;

    // PWM duty 4, then mid-period change to 12
    mode = 0; cnt = 4; en = 1;
    @(negedge clk);
    run_count(16, on, pds);
    cnt = 12;
    run_count(16, on, pds); begin int tot = on; end
    chk("pd_first_period", pds, 1);
    en = 1;
    run_count(PER, on, pds);
    chk("duty12_on", on, 24);
    chk("duty12_pd", pds, 1);
    cnt = 0;
    run_count(PER, on, pds);
    cnt = 15;
    run_count(PER, on, pds);
    chk("duty0_on", on, 0);
    run_count(PER, on, pds);
    chk("duty15_on", on, 30);

    // Fresh enable to check the first-period count of duty 4 exactly
    en = 0; @(negedge clk);
    cnt = 4; en = 1; @(negedge clk);
    run_count(PER, on, pds);
    chk("duty4_on", on, 8);
    chk("duty4_pd", pds, 1);

    // Bargraph: value takes effect one period after it is sampled
    mode = 1;
    for (int i = 0; i < 4; i++) begin
      cnt = bar_cnt[i];
      run_count(PER, on, pds);
      run_count(PER, on, pds);
      chk("bargraph", led, bar_exp[i]);
    end

    // Binary, then off with period_done still running
    mode = 2; cnt = 4'b1010;
    run_count(PER, on, pds);
    run_count(PER, on, pds);
    chk("binary", led, 4'b1010);
    mode = 3;
    run_count(PER, on, pds);
    run_count(PER * 2, on, pds);
    chk("off_on", on, 0);
    chk("off_led", led, 0);
    chk("off_pd", pds, 2);

    // Enable drop mid-period, then re-enable
    mode = 0; cnt = 15;
    run_count(PER + 10, on, pds);
    en = 0;
    @(posedge clk); @(negedge clk);
    chk("drop_led", led, 0);
    run_count(3 * PER, on, pds);
    chk("drop_pd", pds, 0);
    cnt = 6; en = 1; @(negedge clk);
    run_count(PER, on, pds);
    chk("reen_on", on, 12);
    chk("reen_pd", pds, 1);

    // Random traffic, including occasional asynchronous clears
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      clr = 0;
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) cnt = CW'($urandom_range(0, STEPS - 1));
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #2 clr = 1;
        #1 chk("rand_clr_led", led, 0);
      end
    end
    @(negedge clk); clr = 0;
    repeat (4) @(negedge clk);
    chk_on = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
